bin2bcd_seq: RTL

// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/bin2bcd_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // Largest value that fits in DIGITS decimal digits; compared at 64 bits so a
  // narrow bin never truncates it (the compare folds to 0 when bin cannot exceed it).
  localparam logic [63:0]      MAXV = 64'(10 ** DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_cmp;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_W-1:0] r_shift;
  logic [SW-1:0]    r_scratch;
  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_scratch_nxt;
  logic             r_cmp;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [SW-1:0]    r_bcd;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the accept / last-iteration strobes that steer the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Add-3 correction: every nibble >= 5 gets +3, no carry across nibbles.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_scratch_nxt = {w_adj[SW-2:0], r_shift[BIN_W-1]};
  assign w_cmp         = (64'(bin) > MAXV);

  // Datapath: latch on accept, one bit per iteration, publish only on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cmp     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shift   <= bin;
        r_scratch <= '0;
        r_cmp     <= w_cmp;
        r_busy    <= 1'b1;
        r_cnt     <= '0;
      end else if (r_state == SHIFT) begin
        r_scratch <= w_scratch_nxt;
        r_shift   <= r_shift << 1;
        r_cnt     <= r_cnt + 1'b1;
        if (w_last) begin
          r_bcd  <= r_cmp ? {SW{1'b1}} : w_scratch_nxt;
          r_ovf  <= r_cmp;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign bcd  = r_bcd;

endmodule
